// File: rtl/trace_pkg.sv
// Shared types and sizing helpers for the trace_dump capture/readout core.
package trace_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    POST,
    LOAD,
    DUMP,
    DONE
  } state_t;

  // Bytes emitted per captured word (BYTES_PER_WORD = DATA_W/8).
  function automatic int unsigned bytes_per_word(input int unsigned data_w);
    return data_w / 8;
  endfunction

  // Width of the byte index within a word; at least one bit.
  function automatic int unsigned byte_idx_w(input int unsigned data_w);
    return (data_w / 8 > 1) ? $clog2(data_w / 8) : 1;
  endfunction

endpackage

// File: rtl/trace_dump_if.sv
// Byte-stream readout channel (valid/ready) from trace_dump to its sink.
interface trace_dump_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/trace_ram.sv
// Simple dual-port capture buffer: one write port, one registered read port.
module trace_ram #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] q
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) q <= mem[raddr];
  end
endmodule

// File: rtl/trace_dump.sv
// Logic-capture core: circular capture with masked trigger, then oldest-first
// little-endian byte readout over a valid/ready stream.
module trace_dump
  import trace_pkg::*;
#(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned POST_TRIG = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic [DATA_W-1:0] data,
  input  logic [31:0]       trig0,
  input  logic [31:0]       trig_value,
  input  logic [31:0]       trig_mask,
  trace_dump_if.master      tx,
  output logic              busy,
  output logic              triggered,
  output logic              done
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned BPW   = bytes_per_word(DATA_W);
  localparam int unsigned BIW   = byte_idx_w(DATA_W);

  localparam logic [CNT_W-1:0] FULL      = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST_TRIG - 1);
  localparam logic [BIW-1:0]   LAST_BYTE = BIW'(BPW - 1);

  state_t state, state_nx;

  logic [ADDR_W-1:0] wr_ptr, rd_ptr, rd_addr;
  logic [CNT_W-1:0]  fill, post_left, words_left;
  logic [DATA_W-1:0] ram_q, cur;
  logic [BIW-1:0]    byte_idx;
  logic              pf_valid, tx_valid_r;
  logic              match, capture, arm_ok, fill_full;
  logic              accept, last_acc, load_cur, rd_en, dump_end;

  assign match     = ((trig0 ^ trig_value) & trig_mask) == '0;
  assign capture   = (state == ARMED) || (state == POST);
  assign arm_ok    = arm && ((state == IDLE) || (state == DONE));
  assign fill_full = (fill == FULL);

  // The first read is issued from LOAD so the RAM output acts as a one-word
  // prefetch buffer; the next word is fetched as soon as that buffer empties.
  assign accept   = tx_valid_r && tx.tx_ready;
  assign last_acc = accept && (byte_idx == LAST_BYTE);
  assign load_cur = (state == DUMP) && pf_valid && (!tx_valid_r || last_acc);
  assign rd_en    = (state == LOAD) ||
                    ((state == DUMP) && (words_left != '0) && (!pf_valid || load_cur));
  assign rd_addr  = (state == LOAD) ? (fill_full ? wr_ptr : '0) : rd_ptr;
  assign dump_end = (state == DUMP) && last_acc && (words_left == '0) && !pf_valid;

  assign tx.tx_data  = cur[7:0];
  assign tx.tx_valid = tx_valid_r;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (arm) state_nx = ARMED;
      end
      ARMED: if (match) state_nx = (POST_TRIG == 1) ? LOAD : POST;
      POST:  if (post_left == CNT_W'(1)) state_nx = LOAD;
      LOAD:  state_nx = DUMP;
      DUMP:  if (dump_end) state_nx = DONE;
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (arm) state_nx = ARMED;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      fill      <= '0;
      post_left <= '0;
      triggered <= 1'b0;
    end else begin
      if (arm_ok) begin
        wr_ptr    <= '0;
        fill      <= '0;
        triggered <= 1'b0;
      end else if (capture) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
        if (!fill_full) fill <= fill + CNT_W'(1);
      end
      if ((state == ARMED) && match) begin
        triggered <= 1'b1;
        post_left <= POST_LAST;
      end else if (state == POST) begin
        post_left <= post_left - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      words_left <= '0;
      pf_valid   <= 1'b0;
      tx_valid_r <= 1'b0;
      cur        <= '0;
      byte_idx   <= '0;
    end else begin
      if (rd_en) begin
        rd_ptr     <= rd_addr + ADDR_W'(1);
        words_left <= ((state == LOAD) ? fill : words_left) - CNT_W'(1);
      end
      if (rd_en)         pf_valid <= 1'b1;
      else if (load_cur) pf_valid <= 1'b0;

      if (load_cur) begin
        cur        <= ram_q;
        byte_idx   <= '0;
        tx_valid_r <= 1'b1;
      end else if (accept) begin
        cur      <= cur >> 8;
        byte_idx <= byte_idx + BIW'(1);
        if (last_acc) tx_valid_r <= 1'b0;
      end
    end
  end

  trace_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk  (clk),
    .we   (capture),
    .waddr(wr_ptr),
    .wdata(data),
    .re   (rd_en),
    .raddr(rd_addr),
    .q    (ram_q)
  );
endmodule

// File: tb/tb_trace_dump.sv
// Directed bench for trace_dump: latency, window placement, backpressure,
// ignored arm, reset mid-readout and the never-triggered case.
module tb_trace_dump;
  localparam int unsigned PT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm;
  logic [31:0] data;
  logic [31:0] trig0, trig_value, trig_mask;
  logic        busy, triggered, done;

  trace_dump_if txi ();

  trace_dump #(
    .ADDR_W   (12),
    .DATA_W   (32),
    .POST_TRIG(PT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .arm       (arm),
    .data      (data),
    .trig0     (trig0),
    .trig_value(trig_value),
    .trig_mask (trig_mask),
    .tx        (txi),
    .busy      (busy),
    .triggered (triggered),
    .done      (done)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;
  int unsigned base = 0;

  logic [7:0] got[$];
  logic [7:0] ref_bytes[$];
  int unsigned first_valid, first_trig, done_cyc, last_acc, stab_err;

  // data = number of cycles since the first ARMED cycle of the latest arm
  initial begin
    data = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      data = cyc - base;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Returns at the negedge of the first ARMED cycle (data == 0 there).
  task automatic do_arm();
    @(negedge clk);
    arm  = 1'b1;
    base = cyc + 1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic pulse_trig(input int unsigned n);
    repeat (n) @(negedge clk);
    trig0 = 32'hDEAD_0000;
    @(negedge clk);
    trig0 = '0;
  endtask

  // Cycle i = 1 is the current negedge. Acceptance decided from values seen
  // at the negedge preceding the accepting posedge.
  task automatic collect(input int unsigned max_cycles, input bit rnd,
                         input int unsigned stop_bytes,
                         input int unsigned arm1, input int unsigned arm2);
    bit          prev_hold;
    logic [7:0]  prev_data;
    got.delete();
    first_valid = 0; first_trig = 0; done_cyc = 0; last_acc = 0; stab_err = 0;
    prev_hold = 1'b0;
    prev_data = '0;
    for (int unsigned i = 1; i <= max_cycles; i++) begin
      arm = (i == arm1) || (i == arm2);
      txi.tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_hold && (txi.tx_data !== prev_data)) stab_err++;
      if (first_trig == 0 && triggered) first_trig = i;
      if (done) begin
        done_cyc = i;
        break;
      end
      if (txi.tx_valid) begin
        if (first_valid == 0) first_valid = i;
        if (txi.tx_ready) begin
          got.push_back(txi.tx_data);
          last_acc = i;
        end
      end
      prev_hold = txi.tx_valid && !txi.tx_ready;
      prev_data = txi.tx_data;
      if (stop_bytes != 0 && got.size() == int'(stop_bytes)) break;
      @(negedge clk);
    end
    arm = 1'b0;
    txi.tx_ready = 1'b1;
    if (stop_bytes == 0) check_eq("done_reached", 32'(done_cyc != 0), 32'd1);
  endtask

  function automatic logic [31:0] word_at(input int unsigned k);
    if (4 * k + 3 >= got.size()) return 'x;
    return {got[4*k+3], got[4*k+2], got[4*k+1], got[4*k]};
  endfunction

  task automatic scan(input string tag, input int unsigned nwords, input logic [31:0] first);
    int unsigned bad = 0;
    check_eq({tag, "_bytes"}, 32'(got.size()), 32'(nwords * 4));
    for (int unsigned k = 0; k < nwords; k++)
      if (word_at(k) !== first + k) bad++;
    check_eq({tag, "_seq_errs"}, bad, 0);
  endtask

  initial begin
    int unsigned nb, nv, diff;
    rst = 1'b1; arm = 1'b0;
    trig0 = '0; trig_value = '0; trig_mask = '0;
    txi.tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_tx_data", 32'(txi.tx_data), 0);
    check_eq("rst_tx_valid", 32'(txi.tx_valid), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_triggered", 32'(triggered), 0);
    check_eq("rst_done", 32'(done), 0);
    rst = 1'b0;

    // Immediate trigger: 16 words 0..15, first byte in cycle 19, done in 83
    do_arm();
    collect(300, 1'b0, 0, 0, 0);
    check_eq("imm_first_valid", first_valid, 19);
    check_eq("imm_trig_rise", first_trig, 2);
    check_eq("imm_done_cycle", done_cyc, 83);
    check_eq("imm_done_after_last", done_cyc - last_acc, 1);
    check_eq("imm_b0", 32'(got[0]), 32'h00);
    check_eq("imm_b3", 32'(got[3]), 32'h00);
    check_eq("imm_b4", 32'(got[4]), 32'h01);
    check_eq("imm_b5", 32'(got[5]), 32'h00);
    scan("imm", 16, 0);
    check_eq("imm_done", 32'(done), 1);
    check_eq("imm_busy", 32'(busy), 0);
    ref_bytes = got;

    // Random backpressure: same bytes, held data stable
    do_arm();
    check_eq("rearm_trig_clr", 32'(triggered), 0);
    collect(2000, 1'b1, 0, 0, 0);
    check_eq("bp_count", 32'(got.size()), 32'(ref_bytes.size()));
    diff = 0;
    foreach (ref_bytes[k]) if (k >= got.size() || got[k] !== ref_bytes[k]) diff++;
    check_eq("bp_diff", diff, 0);
    check_eq("bp_stable_errs", stab_err, 0);
    check_eq("bp_done_after_last", done_cyc - last_acc, 1);

    // arm during POST (cycle 5) and DUMP (cycle 30) must be ignored
    do_arm();
    collect(300, 1'b0, 0, 5, 30);
    scan("armign", 16, 0);
    check_eq("armign_done_cycle", done_cyc, 83);
    check_eq("armign_triggered", 32'(triggered), 1);

    // Full wrap: trigger at sample 10000, window 5920..10015
    trig_mask  = 32'hFFFF_0000;
    trig_value = 32'hDEAD_0000;
    trig0      = '0;
    do_arm();
    pulse_trig(10000);
    collect(20000, 1'b0, 0, 0, 0);
    scan("wrap", 4096, 32'd5920);
    check_eq("wrap_trig_word", word_at(4096 - PT), 32'd10000);

    // Reset after 100 bytes of a 216-word short capture
    do_arm();
    pulse_trig(200);
    collect(2000, 1'b0, 100, 0, 0);
    check_eq("short_count", 32'(got.size()), 100);
    check_eq("short_w0", word_at(0), 0);
    check_eq("short_w24", word_at(24), 24);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_tx_valid", 32'(txi.tx_valid), 0);
    check_eq("mid_rst_busy", 32'(busy), 0);
    check_eq("mid_rst_done", 32'(done), 0);
    check_eq("mid_rst_triggered", 32'(triggered), 0);
    rst = 1'b0;
    do_arm();
    pulse_trig(4200);
    collect(20000, 1'b0, 0, 0, 0);
    scan("rearm", 4096, 32'd120);

    // Never-matching trigger: stays busy, no output
    trig_mask  = 32'hFFFF_FFFF;
    trig_value = 32'h1234_5678;
    trig0      = '0;
    do_arm();
    nb = 0; nv = 0;
    repeat (5000) begin
      if (!busy) nb++;
      if (txi.tx_valid) nv++;
      @(negedge clk);
    end
    check_eq("notrig_busy_low", nb, 0);
    check_eq("notrig_valid", nv, 0);
    check_eq("notrig_triggered", 32'(triggered), 0);
    check_eq("notrig_done", 32'(done), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
